// File: rtl/life_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_pkg : shared types and constants for the Game-of-Life engine    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package life_pkg;

   localparam int ROWS   = 8;
   localparam int COLS   = 8;
   localparam int LINE_W = COLS * 8;

   localparam logic [1:0] FLAG_HOLD    = 2'b00;
   localparam logic [1:0] FLAG_WRITE   = 2'b01;
   localparam logic [1:0] FLAG_REPLACE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COMMIT = 2'd2,
      ST_SWAP   = 2'd3
   } state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/life_rule.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_rule : Conway rule for one cell from three memory row lines     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module life_rule
   import life_pkg::*;
(
   input  logic [LINE_W-1:0] i_prev_line,
   input  logic [LINE_W-1:0] i_curr_line,
   input  logic [LINE_W-1:0] i_next_line,
   input  logic [2:0]        i_col,
   output logic [3:0]        o_count,
   output logic              o_next_alive
);

   logic [COLS-1:0] w_above_alive;
   logic [COLS-1:0] w_row_alive;
   logic [COLS-1:0] w_below_alive;
   logic [2:0]      w_col_l;
   logic [2:0]      w_col_r;
   logic [7:0]      w_nbrs;
   logic            w_self;

   // A cell is alive when any bit of its byte is set.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign w_above_alive[c] = |i_prev_line[8*c +: 8];
      assign w_row_alive[c]   = |i_curr_line[8*c +: 8];
      assign w_below_alive[c] = |i_next_line[8*c +: 8];
   end

   // 3-bit arithmetic gives the horizontal wrap for free.
   assign w_col_l = i_col - 3'd1;
   assign w_col_r = i_col + 3'd1;
   assign w_self  = w_row_alive[i_col];

   assign w_nbrs = {w_above_alive[w_col_l], w_above_alive[i_col], w_above_alive[w_col_r],
                    w_row_alive[w_col_l],                         w_row_alive[w_col_r],
                    w_below_alive[w_col_l], w_below_alive[i_col], w_below_alive[w_col_r]};

   assign o_count      = popcount8(w_nbrs);
   assign o_next_alive = (o_count == 4'd3) || (w_self && (o_count == 4'd2));

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_engine : per-generation sweep sequencer for the 8x8 frame memory |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module life_engine
   import life_pkg::*;
#(
   parameter int unsigned GEN_TICKS   = 12_000_000,
   parameter logic [7:0]  ALIVE_VALUE = 8'hFF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              step,
   input  logic [LINE_W-1:0] previous_line,
   input  logic [LINE_W-1:0] current_line,
   input  logic [LINE_W-1:0] next_line,
   output logic [5:0]        pixel,
   output logic [7:0]        new_pixel_value,
   output logic [1:0]        write_flag,
   output logic              busy,
   output logic [15:0]       generation
);

   localparam int unsigned          c_timer_w   = $clog2(GEN_TICKS);
   localparam logic [c_timer_w-1:0] c_tick_last = c_timer_w'(GEN_TICKS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [5:0]           r_pixel;
   logic [5:0]           w_pixel_nxt;
   logic [1:0]           r_flag;
   logic [1:0]           w_flag_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic [15:0]          r_gen;
   logic [15:0]          w_gen_nxt;
   logic [c_timer_w-1:0] r_timer;
   logic [c_timer_w-1:0] w_timer_nxt;
   logic                 w_tick_due;
   logic                 w_next_alive;
   logic [3:0]           w_count_unused;

   life_rule u_rule (
      .i_prev_line  (previous_line),
      .i_curr_line  (current_line),
      .i_next_line  (next_line),
      .i_col        (r_pixel[2:0]),
      .o_count      (w_count_unused),
      .o_next_alive (w_next_alive)
   );

   assign w_tick_due = run && (r_timer == c_tick_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pixel <= '0;
         r_flag  <= FLAG_HOLD;
         r_busy  <= 1'b0;
         r_gen   <= '0;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pixel <= w_pixel_nxt;
         r_flag  <= w_flag_nxt;
         r_busy  <= w_busy_nxt;
         r_gen   <= w_gen_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pixel_nxt = r_pixel;
      w_timer_nxt = r_timer;
      w_gen_nxt   = r_gen;
      w_flag_nxt  = FLAG_HOLD;
      w_busy_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (step || w_tick_due) begin
               w_state_nxt = ST_SETTLE;
               w_pixel_nxt = '0;
               w_timer_nxt = '0;
            end else if (run) begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         ST_SETTLE: begin
            w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (r_pixel == 6'd63) begin
               w_state_nxt = ST_SWAP;
            end else begin
               w_state_nxt = ST_SETTLE;
               w_pixel_nxt = r_pixel + 6'd1;
            end
         end
         ST_SWAP: begin
            w_state_nxt = ST_IDLE;
            w_gen_nxt   = r_gen + 16'd1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Flag and busy are decoded from the next state so they line up with it once registered.
      unique case (w_state_nxt)
         ST_SETTLE, ST_COMMIT: begin
            w_flag_nxt = FLAG_WRITE;
            w_busy_nxt = 1'b1;
         end
         ST_SWAP: begin
            w_flag_nxt = FLAG_REPLACE;
            w_busy_nxt = 1'b1;
         end
         default: begin
            w_flag_nxt = FLAG_HOLD;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   assign pixel           = r_pixel;
   assign write_flag      = r_flag;
   assign busy            = r_busy;
   assign generation      = r_gen;
   assign new_pixel_value = ((r_state == ST_COMMIT) && w_next_alive) ? ALIVE_VALUE : 8'h00;

endmodule
`default_nettype wire
